// File: rtl/mem_arbiter.sv
// Two-client memory port arbiter: D has fixed priority, bounded by an I-starvation
// counter; a per-tag owner table routes load responses back to the issuing client.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = 64,
  parameter int TAG_W        = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         i_command,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [1:0]         d_command,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_data,
  input  logic [1:0]         d_size,
  input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
  input  logic [BLOCK_W-1:0] mem2proc_data,
  input  logic [TAG_W-1:0]   mem2proc_data_tag,
  output logic [1:0]         proc2mem_command,
  output logic [ADDR_W-1:0]  proc2mem_addr,
  output logic [BLOCK_W-1:0] proc2mem_data,
  output logic [1:0]         proc2mem_size,
  output logic [TAG_W-1:0]   i_transaction_tag,
  output logic [TAG_W-1:0]   d_transaction_tag,
  output logic [BLOCK_W-1:0] i_data,
  output logic [BLOCK_W-1:0] d_data_out,
  output logic [TAG_W-1:0]   i_data_tag,
  output logic [TAG_W-1:0]   d_data_tag
);
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] DOUBLE   = 2'd3;
  localparam int ENTRIES = 1 << TAG_W;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0]      starve_cnt;
  logic [ENTRIES-1:0] tbl_valid;
  logic [ENTRIES-1:0] tbl_owner;  // 1 = D, 0 = I
  logic i_req, d_req, grant_i, grant_d, accepted, resp_hit;

  always_comb begin
    i_req    = i_command != MEM_NONE;
    d_req    = d_command != MEM_NONE;
    grant_i  = i_req && (!d_req || starve_cnt == LIMIT);
    grant_d  = d_req && !grant_i;
    accepted = !reset && (grant_i || grant_d) && (mem2proc_transaction_tag != '0);
    resp_hit = !reset && (mem2proc_data_tag != '0) && tbl_valid[mem2proc_data_tag];
  end

  always_comb begin
    proc2mem_command  = MEM_NONE;
    proc2mem_addr     = '0;
    proc2mem_data     = '0;
    proc2mem_size     = DOUBLE;
    i_transaction_tag = '0;
    d_transaction_tag = '0;
    i_data_tag        = '0;
    d_data_tag        = '0;
    i_data            = mem2proc_data;
    d_data_out        = mem2proc_data;
    if (!reset) begin
      if (grant_d) begin
        proc2mem_command = d_command;
        proc2mem_addr    = d_addr;
        proc2mem_data    = d_data;
        proc2mem_size    = d_size;
      end else if (grant_i) begin
        proc2mem_command = i_command;
        proc2mem_addr    = i_addr;
      end
    end
    if (accepted && grant_i) i_transaction_tag = mem2proc_transaction_tag;
    if (accepted && grant_d) d_transaction_tag = mem2proc_transaction_tag;
    if (resp_hit && !tbl_owner[mem2proc_data_tag]) i_data_tag = mem2proc_data_tag;
    if (resp_hit &&  tbl_owner[mem2proc_data_tag]) d_data_tag = mem2proc_data_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_valid  <= '0;
      tbl_owner  <= '0;
      starve_cnt <= '0;
    end else begin
      if (resp_hit) tbl_valid[mem2proc_data_tag] <= 1'b0;
      // allocation is written after retire so a same-tag reuse keeps the new owner
      if (accepted && proc2mem_command == MEM_LOAD) begin
        tbl_valid[mem2proc_transaction_tag] <= 1'b1;
        tbl_owner[mem2proc_transaction_tag] <= grant_d;
      end
      if (grant_i || !i_req)       starve_cnt <= '0;
      else if (starve_cnt < LIMIT) starve_cnt <= starve_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a tag-ownership / denied-streak model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
  localparam logic [1:0] WORD = 2'd2, DOUBLE = 2'd3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  i_command = NONE, d_command = NONE, d_size = DOUBLE;
  logic [31:0] i_addr = '0, d_addr = '0;
  logic [63:0] d_data = '0, mem2proc_data = '0;
  logic [3:0]  mem2proc_transaction_tag = '0, mem2proc_data_tag = '0;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data, i_data, d_data_out;
  logic [3:0]  i_transaction_tag, d_transaction_tag, i_data_tag, d_data_tag;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .i_command(i_command), .i_addr(i_addr),
    .d_command(d_command), .d_addr(d_addr), .d_data(d_data), .d_size(d_size),
    .mem2proc_transaction_tag(mem2proc_transaction_tag),
    .mem2proc_data(mem2proc_data), .mem2proc_data_tag(mem2proc_data_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .i_transaction_tag(i_transaction_tag), .d_transaction_tag(d_transaction_tag),
    .i_data(i_data), .d_data_out(d_data_out),
    .i_data_tag(i_data_tag), .d_data_tag(d_data_tag)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic [3:0]  itt, dtt, idt, ddt;
    logic [63:0] idat, ddat;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0, errors = 0;
  int   owner[16];   // 0 = no outstanding load, 1 = I, 2 = D
  int   denied = 0;  // consecutive cycles I asked and D was granted

  // Drive one cycle of inputs and queue what every output must show that cycle.
  task automatic step(input logic [1:0] ic, input logic [31:0] ia,
                      input logic [1:0] dc, input logic [31:0] da,
                      input logic [63:0] dd, input logic [1:0] ds,
                      input logic [3:0] tt, input logic [3:0] dt, input logic rst);
    exp_t e;
    int   win;
    @(posedge clock); #1;
    reset = rst; i_command = ic; i_addr = ia; d_command = dc; d_addr = da;
    d_data = dd; d_size = ds; mem2proc_transaction_tag = tt; mem2proc_data_tag = dt;
    mem2proc_data = {$urandom, $urandom};
    e = '0;
    e.size = DOUBLE;
    e.idat = mem2proc_data;
    e.ddat = mem2proc_data;
    if (rst) begin
      foreach (owner[k]) owner[k] = 0;
      denied = 0;
    end else begin
      win = 0;
      if (ic != NONE && dc != NONE) win = (denied >= LIMIT) ? 1 : 2;
      else if (ic != NONE)          win = 1;
      else if (dc != NONE)          win = 2;
      if (win == 1) begin e.cmd = ic; e.addr = ia; e.itt = tt; end
      if (win == 2) begin e.cmd = dc; e.addr = da; e.data = dd; e.size = ds; e.dtt = tt; end
      if (dt != 0 && owner[dt] != 0) begin
        if (owner[dt] == 1) e.idt = dt; else e.ddt = dt;
        owner[dt] = 0;
      end
      if (win != 0 && tt != 0 && e.cmd == LOAD) owner[tt] = win;
      denied = (ic != NONE && win == 2) ? denied + 1 : 0;
    end
    sbq.push_back(e);
  endtask

  task automatic idle(input logic rst);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 0, 0, rst);
  endtask

  always @(negedge clock) begin
    exp_t e, a;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = '{cmd: proc2mem_command, addr: proc2mem_addr, data: proc2mem_data,
            size: proc2mem_size, itt: i_transaction_tag, dtt: d_transaction_tag,
            idt: i_data_tag, ddt: d_data_tag, idat: i_data, ddat: d_data_out};
      vectors++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got cmd=%0d addr=%h size=%0d itt=%0d dtt=%0d idt=%0d ddt=%0d exp cmd=%0d addr=%h size=%0d itt=%0d dtt=%0d idt=%0d ddt=%0d data_ok=%0d",
                 $time, a.cmd, a.addr, a.size, a.itt, a.dtt, a.idt, a.ddt,
                 e.cmd, e.addr, e.size, e.itt, e.dtt, e.idt, e.ddt,
                 (a.data === e.data && a.idat === e.idat && a.ddat === e.ddat));
      end
    end
  end

  initial begin
    foreach (owner[k]) owner[k] = 0;
    // reset forces outputs even with live requests and an accept tag
    step(LOAD, 32'h1000, LOAD, 32'h2000, 64'hAB, WORD, 4'd3, 4'd3, 1'b1);
    idle(1'b1);

    // I-only load, tag 3, then its response, then a stale repeat
    step(LOAD, 32'h1000, NONE, 0, 0, DOUBLE, 4'd3, 4'd0, 1'b0);
    idle(1'b0);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd3, 1'b0);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd3, 1'b0);

    // both requesting continuously: D x4, I x1, D x4
    idle(1'b1);
    for (int c = 0; c < 10; c++)
      step(LOAD, 32'h100 + c, LOAD, 32'h200 + c, 64'(c), WORD, 4'(c + 1), 4'd0, 1'b0);

    // D store: no table entry, later tag 5 response goes nowhere
    idle(1'b1);
    step(NONE, 0, STORE, 32'h2000, 64'hDEAD_BEEF, WORD, 4'd5, 4'd0, 1'b0);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd5, 1'b0);

    // D load rejected three times then accepted on tag 7
    for (int c = 0; c < 3; c++)
      step(NONE, 0, LOAD, 32'h3000, 0, DOUBLE, 4'd0, 4'd0, 1'b0);
    step(NONE, 0, LOAD, 32'h3000, 0, DOUBLE, 4'd7, 4'd0, 1'b0);
    for (int t = 1; t < 16; t++)
      step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'(t), 1'b0);

    // outstanding loads dropped by reset
    step(LOAD, 32'h40, NONE, 0, 0, DOUBLE, 4'd2, 4'd0, 1'b0);
    step(NONE, 0, LOAD, 32'h80, 0, DOUBLE, 4'd9, 4'd0, 1'b0);
    step(LOAD, 32'h44, LOAD, 32'h84, 0, DOUBLE, 4'd0, 4'd0, 1'b1);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd2, 1'b0);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd9, 1'b0);

    // same-cycle retire of I's tag 4 and reallocation to D
    step(LOAD, 32'h500, NONE, 0, 0, DOUBLE, 4'd4, 4'd0, 1'b0);
    step(NONE, 0, LOAD, 32'h600, 0, DOUBLE, 4'd4, 4'd4, 1'b0);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd4, 1'b0);
    step(NONE, 0, NONE, 0, 0, DOUBLE, 4'd0, 4'd4, 1'b0);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      logic [1:0] ic, dc, ds;
      logic [3:0] tt, dt;
      ic = ($urandom_range(0, 3) != 0) ? LOAD : NONE;
      dc = 2'($urandom_range(0, 2));
      ds = 2'($urandom_range(0, 3));
      tt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      dt = 4'($urandom_range(0, 15));
      step(ic, $urandom, dc, $urandom, {$urandom, $urandom}, ds, tt, dt,
           ($urandom_range(0, 59) == 0));
    end

    // drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clock);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter between the processor's single memory port and its two memory clients: the instruction-cache fetch path (client I) and the data-side MSHR (client D). Each cycle it grants the port to one client, passes that client's command through, and returns memory's transaction tag only to the granted client. It keeps an owner table for outstanding loads so each data response (by tag) reaches only the client that issued it. A starvation counter bounds how long D's fixed priority can block I.

## Interface
- STARVE_LIMIT, 4: consecutive I-denied cycles after which I is force-granted (≥1).
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- i_command  in  MEM_COMMAND  I request (MEM_NONE = idle)
- i_addr  in  ADDR  I request address
- d_command  in  MEM_COMMAND  D request (MEM_LOAD or MEM_STORE)
- d_addr  in  ADDR  D request address
- d_data  in  MEM_BLOCK  D store data
- d_size  in  MEM_SIZE  D store size
- mem2proc_transaction_tag  in  MEM_TAG  nonzero = request accepted this cycle
- mem2proc_data  in  MEM_BLOCK  response data
- mem2proc_data_tag  in  MEM_TAG  nonzero = response valid for that tag
- proc2mem_command  out  MEM_COMMAND  granted command
- proc2mem_addr  out  ADDR  granted address
- proc2mem_data  out  MEM_BLOCK  D data when D granted, else 0
- proc2mem_size  out  MEM_SIZE  D size when D granted, else DOUBLE
- i_transaction_tag  out  MEM_TAG  accept tag to I, 0 if not granted
- d_transaction_tag  out  MEM_TAG  accept tag to D, 0 if not granted
- i_data, d_data_out  out  MEM_BLOCK  mem2proc_data forwarded
- i_data_tag, d_data_tag  out  MEM_TAG  response tag if owner matches, else 0

## Operation
- Grant (combinational): only one requests -> it wins. Both request -> D wins unless starve_cnt == STARVE_LIMIT, then I wins. Neither -> proc2mem_command = MEM_NONE, addr/data 0.
- Acceptance: granted request is accepted iff mem2proc_transaction_tag != 0 that cycle. Granted client sees the tag on its *_transaction_tag; the other sees 0. Tag 0 = not accepted; the client holds and retries (stateless for arbiter).
- Owner table: 16 entries {valid, owner}, indexed by MEM_TAG; entry 0 never used. An accepted MEM_LOAD writes entry[tag] = {1, granted client}. An accepted MEM_STORE writes nothing (no response expected).
- Response routing: if mem2proc_data_tag != 0 and entry valid -> drive that tag on the owner's *_data_tag, 0 to the other; clear the entry next edge. Tag with no valid entry -> both data tags 0, table unchanged. Data buses always forward mem2proc_data.
- Same tag retired and re-allocated in one cycle: retire routes to the old owner; the new allocation is what remains in the table.
- Starvation counter starve_cnt (width $clog2(STARVE_LIMIT+1)): +1 when I requests, D is granted, and cnt < limit. Reset to 0 when I is granted or I is idle. Counts grant cycles, not acceptances.

## Timing
- Grant, proc2mem_* and *_transaction_tag combinational from same-cycle inputs: zero-cycle request latency.
- Response routing combinational from mem2proc_data_tag and registered table: zero-cycle response latency.
- Table and counter update on posedge clock.
- Reset: table cleared, starve_cnt = 0. While reset is high, outputs are forced: proc2mem_command = MEM_NONE, all *_transaction_tag and *_data_tag = 0, proc2mem_addr/data = 0. Outstanding responses arriving after reset are dropped (no valid entry).
- Reset mid-transaction needs no special handling; the cleared table alone covers it.

## Test plan
- Only I issues MEM_LOAD 0x1000, memory returns tag 3 -> proc2mem_addr 0x1000, i_transaction_tag 3, d_transaction_tag 0; later data_tag 3 -> i_data_tag 3, d_data_tag 0, entry 3 cleared.
- Both request continuously, STARVE_LIMIT 4, memory always accepts -> D granted cycles 0-3, I granted cycle 4, D again cycles 5-8.
- D MEM_STORE to 0x2000 size WORD, tag 5 -> proc2mem_command MEM_STORE, size WORD, d_transaction_tag 5; no table entry; a later data_tag 5 -> both data tags 0.
- Memory rejects (tag 0) a granted D load for 3 cycles, then accepts with tag 7 -> d_transaction_tag 0,0,0,7; only entry 7 allocated.
- Loads outstanding on tags 2 (I) and 9 (D); reset asserted one cycle, then data_tag 2 arrives -> both data tags 0; no outputs active during reset.
- data_tag 4 retires an I load while D's new load is accepted with tag 4 the same cycle -> i_data_tag 4 now; next data_tag 4 routes to D.
